piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in serial-out stage that sits directly upstream of the 4-bit SIPO shift register and drives its serial D input, one bit per clk.
- Accepts a WIDTH-bit word through a valid/ready handshake and shifts it out LSB-first or MSB-first.
- Supports gapless back-to-back words and flags the first and last bit of each frame, so the downstream stage knows when its parallel Q is complete.

Parameters:
- WIDTH, 4: bits per word; legal range 2..32; default matches the downstream SIPO depth.
- LSB_FIRST, 1: 1 shifts bit 0 first; 0 shifts bit WIDTH-1 first.
- IDLE_LEVEL, 1'b0: value driven on D when no frame is active.

Ports:
- clk  input  1  rising-edge clock, shared with the downstream SIPO.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- load_valid  input  1  P holds a word to serialize.
- load_ready  output  1  block accepts a word this cycle.
- P  input  WIDTH  parallel word, sampled on an accepted load.
- D  output  1  serial data to the downstream SIPO D input; registered.
- busy  output  1  a frame is being shifted out.
- frame_start  output  1  high while D carries the first bit of a frame.
- frame_last  output  1  high while D carries the last bit of a frame.

Behaviour:
- Reset (rst_n=0 at a rising edge of clk):
  - state=IDLE, shift register=0, bit counter=0.
  - D=IDLE_LEVEL, busy=0, frame_start=0, frame_last=0.
  - load_ready=1 in the first cycle after reset is released.
  - rst_n has priority over every other input.
- States:
  - IDLE: no frame active.
  - SHIFT: a frame is active; the bit counter cnt runs 0..WIDTH-1.
- load_ready is combinational: 1 in IDLE, 1 in SHIFT when cnt==WIDTH-1, otherwise 0.
- Accepted load means load_valid && load_ready at a rising edge. On an accepted load:
  - the shift register captures P;
  - cnt goes to 0 and state goes to SHIFT;
  - D, busy and frame_start present the first bit from the next cycle on.
  - Latency from the accepting edge to the first bit on D is 1 cycle.
- In SHIFT, each rising edge:
  - D = current output bit: shreg[0] when LSB_FIRST=1, shreg[WIDTH-1] when LSB_FIRST=0;
  - the shift register shifts toward the output end and fills with 0;
  - cnt increments.
  - D, frame_start and frame_last are all registered and aligned to the same cycle.
- frame_start=1 exactly when cnt==0 in SHIFT; frame_last=1 exactly when cnt==WIDTH-1 in SHIFT.
- End of frame (cnt==WIDTH-1):
  - with no accepted load, the next state is IDLE and D returns to IDLE_LEVEL;
  - with an accepted load, the next frame's first bit follows with no gap: busy stays 1 and frame_start pulses.
- load_valid while load_ready=0 is ignored: there is no capture and no error, and the word must be held by upstream until it is accepted.
- P may change freely when no load is accepted.
- Reset mid-frame aborts the frame immediately:
  - partial bits are discarded and D=IDLE_LEVEL in the next cycle;
  - a word presented in the same cycle as reset is dropped.
- busy=1 in every cycle that D carries frame data. The block emits exactly WIDTH frame bits per accepted word, never more or fewer.

Test Plan:
- Reset, then WIDTH=4, LSB_FIRST=1, load P=4'b1011 → D=1,1,0,1 over the 4 cycles after the accepting edge, then 0. frame_start on bit 1, frame_last on bit 4. A chained SIPO shows Q=4'b1011 one cycle after frame_last.
- Back-to-back: P=4'b0110 accepted, then P=4'b1001 held valid → second word accepted on the frame_last cycle. D=0,1,1,0,1,0,0,1 with no idle gap and busy=1 for 8 cycles.
- load_valid with P=4'b1111 asserted at cnt=1 of a frame for P=4'b0000 → load_ready=0 at cnt 0..2. The current frame emits 0,0,0,0 unaltered, and 4'b1111 is captured on the frame_last cycle.
- rst_n=0 at cnt=2 of a frame for P=4'b1101 → next cycle D=0, busy=0, no frame_last. After release, load_ready=1 and a new load of 4'b0101 emits 1,0,1,0.
- LSB_FIRST=0, WIDTH=8, P=8'hA5 → D=1,0,1,0,0,1,0,1; frame_last on the eighth bit.
- IDLE_LEVEL=1, no loads for 10 cycles after reset → D=1, busy=0, frame_start=0, load_ready=1 throughout.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Load handshake and serial frame signals between an upstream producer and the PISO stage.
// The slave modport is the serializer's view; the master modport is the producer/monitor view.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] P;
  logic             D;
  logic             busy;
  logic             frame_start;
  logic             frame_last;

  modport slave (
    input  load_valid,
    input  P,
    output load_ready,
    output D,
    output busy,
    output frame_start,
    output frame_last
  );

  modport master (
    output load_valid,
    output P,
    input  load_ready,
    input  D,
    input  busy,
    input  frame_start,
    input  frame_last
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in serial-out stage: accepts a WIDTH-bit word on a valid/ready handshake and
// shifts it out one bit per clk, gaplessly back-to-back, with first/last-bit frame flags.
module piso_serializer #(
  parameter int unsigned WIDTH      = 4,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic           clk,
  input  logic           rst_n,
  piso_serializer_if.slave bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_shreg;
  logic               r_d;
  logic               r_busy;
  logic               r_frame_start;
  logic               r_frame_last;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [WIDTH-1:0]   w_shreg_nxt;
  logic               w_d_nxt;
  logic               w_busy_nxt;
  logic               w_frame_start_nxt;
  logic               w_frame_last_nxt;
  logic               w_load_ready;
  logic               w_accept;
  logic [WIDTH-1:0]   w_p;
  logic               w_p_first_bit;
  logic [WIDTH-1:0]   w_p_rest;
  logic               w_shreg_out_bit;
  logic [WIDTH-1:0]   w_shreg_shifted;
  logic [CNT_W-1:0]   w_cnt_inc;

  assign w_p             = bus.P;
  assign w_load_ready    = (r_state == IDLE) || (r_cnt == CNT_LAST);
  assign w_accept        = bus.load_valid && w_load_ready;
  assign w_cnt_inc       = r_cnt + CNT_W'(1);

  // The D register holds the bit on the wire; the shift register holds the bits still to come.
  assign w_p_first_bit   = LSB_FIRST ? w_p[0] : w_p[WIDTH-1];
  assign w_p_rest        = LSB_FIRST ? (w_p >> 1) : (w_p << 1);
  assign w_shreg_out_bit = LSB_FIRST ? r_shreg[0] : r_shreg[WIDTH-1];
  assign w_shreg_shifted = LSB_FIRST ? (r_shreg >> 1) : (r_shreg << 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_shreg       <= '0;
      r_d           <= IDLE_LEVEL;
      r_busy        <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_last  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_shreg       <= w_shreg_nxt;
      r_d           <= w_d_nxt;
      r_busy        <= w_busy_nxt;
      r_frame_start <= w_frame_start_nxt;
      r_frame_last  <= w_frame_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_shreg_nxt       = r_shreg;
    w_d_nxt           = IDLE_LEVEL;
    w_busy_nxt        = 1'b0;
    w_frame_start_nxt = 1'b0;
    w_frame_last_nxt  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt       = SHIFT;
          w_cnt_nxt         = '0;
          w_shreg_nxt       = w_p_rest;
          w_d_nxt           = w_p_first_bit;
          w_busy_nxt        = 1'b1;
          w_frame_start_nxt = 1'b1;
          w_frame_last_nxt  = (CNT_LAST == '0);
        end
      end
      SHIFT: begin
        if (r_cnt == CNT_LAST) begin
          // Last bit on the wire: chain the next word gaplessly or fall back to idle.
          if (w_accept) begin
            w_state_nxt       = SHIFT;
            w_cnt_nxt         = '0;
            w_shreg_nxt       = w_p_rest;
            w_d_nxt           = w_p_first_bit;
            w_busy_nxt        = 1'b1;
            w_frame_start_nxt = 1'b1;
            w_frame_last_nxt  = (CNT_LAST == '0);
          end else begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_shreg_nxt = '0;
          end
        end else begin
          w_cnt_nxt        = w_cnt_inc;
          w_shreg_nxt      = w_shreg_shifted;
          w_d_nxt          = w_shreg_out_bit;
          w_busy_nxt       = 1'b1;
          w_frame_last_nxt = (w_cnt_inc == CNT_LAST);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
        w_shreg_nxt = '0;
      end
    endcase
  end

  assign bus.load_ready  = w_load_ready;
  assign bus.D           = r_d;
  assign bus.busy        = r_busy;
  assign bus.frame_start = r_frame_start;
  assign bus.frame_last  = r_frame_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two configurations (4-bit LSB-first idle-0, 8-bit MSB-first idle-1)
// driven by directed and random loads, compared each cycle against a queue-of-bits model.
module tb_piso_serializer;

  typedef struct packed {
    logic d;
    logic first;
    logic last;
  } bit_t;
  typedef bit_t bitq_t[$];

  logic        clk = 1'b0;
  logic        rst_n;
  logic        v_drv [2];
  logic [31:0] p_drv [2];
  logic        acc_last [2];
  bitq_t       mq0;
  bitq_t       mq1;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(4)) if_a ();
  piso_serializer_if #(.WIDTH(8)) if_b ();

  assign if_a.load_valid = v_drv[0];
  assign if_a.P          = p_drv[0][3:0];
  assign if_b.load_valid = v_drv[1];
  assign if_b.P          = p_drv[1][7:0];

  piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Queue head is the bit on D this cycle; an accepted word appends its WIDTH bits in wire order.
  task automatic model_edge(inout bitq_t q, input logic rst, input logic acc,
                            input logic [31:0] p, input int unsigned w, input bit lsb);
    bit_t b;
    int   idx;
    if (!rst) begin
      q.delete();
    end else begin
      if (q.size() > 0) void'(q.pop_front());
      if (acc) begin
        for (int i = 0; i < int'(w); i++) begin
          idx     = lsb ? i : int'(w) - 1 - i;
          b.d     = p[idx];
          b.first = (i == 0);
          b.last  = (i == int'(w) - 1);
          q.push_back(b);
        end
      end
    end
  endtask

  task automatic check_outputs(input string name, input bitq_t q, input logic idle,
                               input logic d, input logic busy, input logic fs,
                               input logic fl, input logic rdy);
    logic e_d, e_busy, e_fs, e_fl, e_rdy;
    if (q.size() == 0) begin
      e_d = idle; e_busy = 1'b0; e_fs = 1'b0; e_fl = 1'b0;
    end else begin
      e_d = q[0].d; e_busy = 1'b1; e_fs = q[0].first; e_fl = q[0].last;
    end
    e_rdy = (q.size() <= 1);
    check({name, "_D"},     32'(d),    32'(e_d));
    check({name, "_busy"},  32'(busy), 32'(e_busy));
    check({name, "_start"}, 32'(fs),   32'(e_fs));
    check({name, "_last"},  32'(fl),   32'(e_fl));
    check({name, "_ready"}, 32'(rdy),  32'(e_rdy));
  endtask

  // Check outputs mid-cycle, then advance one clock and update the model with what the edge saw.
  task automatic cycle();
    logic acc0, acc1, rst_s;
    @(negedge clk);
    check_outputs("a", mq0, 1'b0, if_a.D, if_a.busy, if_a.frame_start, if_a.frame_last, if_a.load_ready);
    check_outputs("b", mq1, 1'b1, if_b.D, if_b.busy, if_b.frame_start, if_b.frame_last, if_b.load_ready);
    rst_s = rst_n;
    acc0  = rst_n && v_drv[0] && (mq0.size() <= 1);
    acc1  = rst_n && v_drv[1] && (mq1.size() <= 1);
    @(posedge clk);
    #1;
    model_edge(mq0, rst_s, acc0, p_drv[0], 4, 1'b1);
    model_edge(mq1, rst_s, acc1, p_drv[1], 8, 1'b0);
    acc_last[0] = acc0;
    acc_last[1] = acc1;
  endtask

  task automatic drive(input logic v, input logic [31:0] p);
    v_drv[0] = v; p_drv[0] = p;
    v_drv[1] = v; p_drv[1] = p;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0);
    acc_last[0] = 1'b0;
    acc_last[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cycle();

    // Idle after reset, then a single word on each configuration.
    rst_n = 1'b1;
    repeat (3) cycle();
    drive(1'b1, 32'h0000_A5_0B);
    p_drv[1] = 32'hA5;
    cycle();
    drive(1'b0, 32'h0);
    repeat (10) cycle();

    // Back-to-back: second word held valid until the frame_last cycle.
    drive(1'b1, 32'h6);
    cycle();
    drive(1'b1, 32'h9);
    repeat (4) cycle();
    drive(1'b0, 32'h0);
    repeat (10) cycle();

    // Word presented while busy is ignored until ready.
    drive(1'b1, 32'h0);
    cycle();
    drive(1'b1, 32'hF);
    repeat (3) cycle();
    drive(1'b0, 32'h0);
    repeat (10) cycle();

    // Reset in the middle of a frame, with a word presented in the reset cycle.
    drive(1'b1, 32'hD);
    cycle();
    drive(1'b0, 32'h0);
    repeat (2) cycle();
    rst_n = 1'b0;
    drive(1'b1, 32'h3);
    cycle();
    rst_n = 1'b1;
    drive(1'b0, 32'h0);
    cycle();
    drive(1'b1, 32'h5);
    cycle();
    drive(1'b0, 32'h0);
    repeat (10) cycle();

    // Random traffic: upstream holds an unaccepted word, reset asserted occasionally.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!v_drv[k] || acc_last[k]) begin
          v_drv[k] = ($urandom_range(0, 3) != 0);
          p_drv[k] = $urandom;
        end
      end
      rst_n = ($urandom_range(0, 99) != 0);
      cycle();
    end

    rst_n = 1'b1;
    drive(1'b0, 32'h0);
    repeat (12) cycle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
